div_iter: RTL
=============

// Module: div_iter
// PURPOSE
//  Iterative restoring divider serving the EX-stage divide handshake (responder side of div/complete).
//  EX holds `div` high while a DIV/DIVU is valid and unexcepted; this block computes quotient/remainder
//  over multiple cycles and raises `complete`. EX stalls until `complete`. EX writes s/r to LO/HI on `accept`.
//  One request in flight; no pipelining of successive divides.
// PARAMETERS
//  WIDTH    32   operand/result width (x, y, s, r)
// PORTS
//  clk         in   1      clock; all state updates on rising edge
//  reset       in   1      asynchronous, active-high reset
//  div         in   1      request level; high = divide wanted; a drop while busy = cancel (flush)
//  div_signed  in   1      1 = DIV (two's complement), 0 = DIVU; sampled at start
//  x           in   WIDTH  dividend; sampled at start
//  y           in   WIDTH  divisor; sampled at start
//  accept      in   1      consumer takes result this cycle (EX not stalled downstream)
//  s           out  WIDTH  quotient; valid while complete=1
//  r           out  WIDTH  remainder; valid while complete=1
//  complete    out  1      result ready; held until accept
//  busy        out  1      high in BUSY or DONE
// BEHAVIOUR
//  Reset: state=IDLE, s=0, r=0, complete=0, busy=0, counter=0. Async assert; release is synchronous to clk.
//  FSM states: IDLE, BUSY, DONE.
//   IDLE: div=1 -> latch |x|, |y|, sign_q=(x^y)[MSB]&signed, sign_r=x[MSB]&signed; cnt=0; -> BUSY.
//   BUSY: one quotient bit per cycle, MSB first: rem={rem,dividend_msb}; if rem>=|y| then rem-=|y|, qbit=1.
//         After WIDTH iterations -> DONE. div=0 in any BUSY cycle -> IDLE, no complete, no result update.
//   DONE: complete=1; s=sign_q ? -q : q; r=sign_r ? -rem : rem (fix-up registered on entry to DONE).
//         accept=1 -> IDLE next cycle (complete drops). div=0 while accept=0 -> IDLE (flush). Otherwise hold.
//  Latency: div rises in cycle N (IDLE) -> complete first high in cycle N+WIDTH+1 (33 for WIDTH=32).
//  Back-to-back: a new request is started only from IDLE; a div held high across accept restarts
//   on the next cycle (one idle bubble). Restart uses operands present in that IDLE cycle.
//  Arithmetic: magnitudes computed as WIDTH-bit unsigned (|0x80000000| = 0x80000000); partial remainder is WIDTH+1 bits.
//  Divide by zero (no exception, result architecturally UNPREDICTABLE, but fixed here):
//   unsigned: s=all ones, r=x. signed: s = x<0 ? 1 : -1, r=x.
//  Overflow 0x80000000 / 0xFFFFFFFF signed: s=0x80000000, r=0.
//  s/r are held constant outside DONE at their last completed value (0 after reset).
//  Reset during BUSY/DONE: immediate IDLE, all outputs 0.
// CONFIGURATION
//  DIV_RADIX4_EN defined: two iterations per BUSY cycle (two cascaded steps), WIDTH/2 BUSY cycles;
//   latency N+WIDTH/2+1 (17). WIDTH must be even.
//  Not defined: radix-2, one step per cycle, latency as above. Results bit-identical in both modes.
// STRUCTURE
//  common.vh: DIV_ST_IDLE/BUSY/DONE state encodings (2-bit), DIV_CNT_W = clog2(WIDTH)+1.
//  Sub-module div_step: combinational single restoring iteration (rem_in, q_in, divisor -> rem_out, q_out);
//   instanced once (radix-2) or twice chained (DIV_RADIX4_EN).
//  Top: FSM, counter, operand/sign registers, sign fix-up, output registers.
// TESTING
//  DIVU x=100 y=7, accept=1 -> complete in cycle 33 after start, s=14, r=2; complete low next cycle.
//  DIV x=-7 (0xFFFFFFF9) y=2 -> s=0xFFFFFFFD, r=0xFFFFFFFF; DIV x=7 y=-2 -> s=0xFFFFFFFD, r=1.
//  DIV x=0x80000000 y=0xFFFFFFFF -> s=0x80000000, r=0; DIVU x=5 y=0 -> s=0xFFFFFFFF, r=5.
//  div dropped at BUSY cycle 10 -> no complete; new DIVU 9/4 one cycle later -> s=2, r=1 after full latency.
//  accept=0 for 3 DONE cycles -> complete, s, r stable; accept=1 -> IDLE; reset pulse mid-BUSY -> all outputs 0.
//  Back-to-back: div held high, accept at first complete -> second result 33 cycles after restart (+1 bubble).

Source files
------------

// File: rtl/div_iter_pkg.sv
// Shared types and sizing for the iterative divider (div_iter).
package div_iter_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

    typedef enum logic [1:0] {
        DIV_ST_IDLE = 2'd0,
        DIV_ST_BUSY = 2'd1,
        DIV_ST_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_iter_if.sv
// EX-stage divide handshake: EX is master (request/accept), divider is slave (result/complete).
interface div_iter_if
    import div_iter_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
);
    logic             div;
    logic             div_signed;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             accept;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic             complete;
    logic             busy;

    modport master (
        output div, div_signed, x, y, accept,
        input  s, r, complete, busy
    );

    modport slave (
        input  div, div_signed, x, y, accept,
        output s, r, complete, busy
    );
endinterface

// File: rtl/div_iter_step.sv
// One restoring-division iteration. quo_i carries the unconsumed dividend bits in its
// upper part; each step shifts one dividend bit into the remainder and one quotient bit in.
module div_iter_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);
    logic [WIDTH:0] shifted;
    logic           take;

    // Trial subtract on the WIDTH+1-bit partial remainder; restore when it would go negative.
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        take    = (shifted >= {1'b0, dvs_i});
        rem_o   = take ? WIDTH'(shifted - {1'b0, dvs_i}) : shifted[WIDTH-1:0];
        quo_o   = {quo_i[WIDTH-2:0], take};
    end
endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider, responder side of the EX div/complete handshake.
// Optional build macro DIV_RADIX4_EN: two chained iterations per BUSY cycle.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic      clk,
    input  logic      reset,
    div_iter_if.slave bus
);
`ifdef DIV_RADIX4_EN
    localparam int unsigned STEPS = 2;
`else
    localparam int unsigned STEPS = 1;
`endif
    localparam int unsigned      CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - STEPS);
    localparam logic [CNT_W-1:0] CNT_INC  = CNT_W'(STEPS);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             sgq_q, sgq_d;
    logic             sgr_q, sgr_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             complete_q, complete_d;
    logic             busy_q, busy_d;

    logic             x_neg, y_neg;
    logic [WIDTH-1:0] x_mag, y_mag;
    logic [WIDTH-1:0] rem_a, quo_a, rem_n, quo_n;

    // Operand magnitudes as WIDTH-bit unsigned, so |most-negative| stays representable.
    always_comb begin
        x_neg = bus.div_signed & bus.x[WIDTH-1];
        y_neg = bus.div_signed & bus.y[WIDTH-1];
        x_mag = x_neg ? (WIDTH'(0) - bus.x) : bus.x;
        y_mag = y_neg ? (WIDTH'(0) - bus.y) : bus.y;
    end

    div_iter_step #(.WIDTH(WIDTH)) u_step0 (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (rem_a),
        .quo_o (quo_a)
    );

`ifdef DIV_RADIX4_EN
    div_iter_step #(.WIDTH(WIDTH)) u_step1 (
        .rem_i (rem_a),
        .quo_i (quo_a),
        .dvs_i (dvs_q),
        .rem_o (rem_n),
        .quo_o (quo_n)
    );
`else
    assign rem_n = rem_a;
    assign quo_n = quo_a;
`endif

    // Next-state, datapath and output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        sgq_d   = sgq_q;
        sgr_d   = sgr_q;
        s_d     = s_q;
        r_d     = r_q;
        case (state_q)
            DIV_ST_IDLE: begin
                if (bus.div) begin
                    state_d = DIV_ST_BUSY;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = x_mag;
                    dvs_d   = y_mag;
                    sgq_d   = x_neg ^ y_neg;
                    sgr_d   = x_neg;
                end
            end
            DIV_ST_BUSY: begin
                if (!bus.div) begin
                    state_d = DIV_ST_IDLE;
                end else begin
                    rem_d = rem_n;
                    quo_d = quo_n;
                    cnt_d = cnt_q + CNT_INC;
                    if (cnt_q == CNT_LAST) begin
                        state_d = DIV_ST_DONE;
                        s_d     = sgq_q ? (WIDTH'(0) - quo_n) : quo_n;
                        r_d     = sgr_q ? (WIDTH'(0) - rem_n) : rem_n;
                    end
                end
            end
            DIV_ST_DONE: begin
                if (bus.accept || !bus.div) begin
                    state_d = DIV_ST_IDLE;
                end
            end
            default: state_d = DIV_ST_IDLE;
        endcase
        complete_d = (state_d == DIV_ST_DONE);
        busy_d     = (state_d != DIV_ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= DIV_ST_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            sgq_q      <= 1'b0;
            sgr_q      <= 1'b0;
            s_q        <= '0;
            r_q        <= '0;
            complete_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            sgq_q      <= sgq_d;
            sgr_q      <= sgr_d;
            s_q        <= s_d;
            r_q        <= r_d;
            complete_q <= complete_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.s        = s_q;
    assign bus.r        = r_q;
    assign bus.complete = complete_q;
    assign bus.busy     = busy_q;
endmodule
